// File: rtl/mont_sequencer_pkg.sv
// Montgomery sequencer shared types and constants.
// Holds the FSM state set, default sizing and phase codes.
package mont_sequencer_pkg;

    localparam int NUM_ITER   = 256;
    localparam int MAX_ROUNDS = 3;

    localparam logic [3:0] PHASE_IDLE = 4'd8;
    localparam logic [3:0] PHASE_LAST = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ITER,
        S_RESOLVE,
        S_SUBLOAD,
        S_SUBRND,
        S_FINISH
    } state_t;

    // Quotient digit that zeroes the low two accumulator bits.
    function automatic logic [1:0] quotDigit(
        input logic [1:0] t,
        input logic [1:0] m
    );
        logic [1:0] prod;
        prod = t * m;
        return ~prod + 2'd1;
    endfunction

endpackage

// File: rtl/mont_digit_sel.sv
// Radix-4 digit selection for the carry-save accumulator.
// Picks the B and M multiples for the current A digit.
module mont_digit_sel (
    input  logic         active,
    input  logic [1:0]   aDigit,
    input  logic [1:0]   cLow,
    input  logic [511:0] b,
    input  logic [511:0] m,
    output logic [511:0] b0,
    output logic [512:0] b1,
    output logic [511:0] m0,
    output logic [512:0] m1
);
    import mont_sequencer_pkg::*;

    logic [1:0] ab;
    logic [1:0] t;
    logic [1:0] q;

    // Multiples are zero unless the accumulator is iterating.
    always_comb begin
        ab = aDigit * b[1:0];
        t  = cLow + ab;
        q  = quotDigit(t, m[1:0]);
        b0 = '0;
        b1 = '0;
        m0 = '0;
        m1 = '0;
        if (active) begin
            if (aDigit[0]) b0 = b;
            if (aDigit[1]) b1 = {b, 1'b0};
            if (q[0])      m0 = m;
            if (q[1])      m1 = {m, 1'b0};
        end
    end

endmodule

// File: rtl/mont_sequencer.sv
// Montgomery multiplication sequencer.
// Steers an external carry-save accumulator through one A*B*2^-512 mod M.
module mont_sequencer #(
    parameter int NUM_ITER   = mont_sequencer_pkg::NUM_ITER,
    parameter int MAX_ROUNDS = mont_sequencer_pkg::MAX_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] in_a,
    input  logic [511:0] in_b,
    input  logic [511:0] in_m,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [511:0] result,
    output logic         add_clear,
    output logic         add_doubleshift,
    output logic [511:0] add_B0,
    output logic [512:0] add_B1,
    output logic [511:0] add_M0,
    output logic [512:0] add_M1,
    output logic         add_subtract,
    output logic [3:0]   add_phase,
    output logic [512:0] add_subtraction,
    input  logic         add_cZero,
    input  logic         add_cOne,
    input  logic         add_carry,
    input  logic [513:0] add_result
);
    import mont_sequencer_pkg::*;

    localparam int CW = $clog2(NUM_ITER + 1);
    localparam int RW = $clog2(MAX_ROUNDS + 1);
    localparam logic [CW-1:0] ITER_LAST   = CW'(NUM_ITER - 1);
    localparam logic [RW-1:0] ROUND_LIMIT = RW'(MAX_ROUNDS);
    localparam logic [2:0]    PH_LAST     = PHASE_LAST[2:0];

    state_t        state;
    state_t        nextState;
    logic [511:0]  aReg;
    logic [511:0]  bReg;
    logic [511:0]  mReg;
    logic [CW-1:0] iterCnt;
    logic [2:0]    phaseCnt;
    logic [RW-1:0] roundCnt;
    logic          errFlag;
    logic          finishErr;
    logic          iterActive;
    logic [1:0]    unusedResultTop;

    assign unusedResultTop = add_result[513:512];

    assign busy            = (state != S_IDLE);
    assign err             = done & errFlag;
    assign add_subtraction = ~{1'b0, mReg} + 513'd1;

    mont_digit_sel u_digit (
        .active (iterActive),
        .aDigit (aReg[1:0]),
        .cLow   ({add_cOne, add_cZero}),
        .b      (bReg),
        .m      (mReg),
        .b0     (add_B0),
        .b1     (add_B1),
        .m0     (add_M0),
        .m1     (add_M1)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nextState;
    end

    // Next-state and accumulator control strobes.
    always_comb begin
        nextState       = state;
        add_clear       = 1'b0;
        add_doubleshift = 1'b0;
        add_subtract    = 1'b0;
        add_phase       = PHASE_IDLE;
        done            = 1'b0;
        iterActive      = 1'b0;
        finishErr       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) nextState = S_CLEAR;
            end
            S_CLEAR: begin
                add_clear = 1'b1;
                nextState = S_ITER;
            end
            S_ITER: begin
                add_doubleshift = 1'b1;
                iterActive      = 1'b1;
                if (iterCnt == ITER_LAST) nextState = S_RESOLVE;
            end
            S_RESOLVE: begin
                add_phase = {1'b0, phaseCnt};
                if (phaseCnt == PH_LAST) nextState = S_SUBLOAD;
            end
            S_SUBLOAD: begin
                add_subtract = 1'b1;
                add_phase    = 4'd0;
                nextState    = S_SUBRND;
            end
            S_SUBRND: begin
                add_subtract = 1'b1;
                add_phase    = {1'b0, phaseCnt};
                if (phaseCnt == PH_LAST) begin
                    if (add_carry) begin
                        nextState = S_FINISH;
                    end else if (roundCnt == ROUND_LIMIT) begin
                        nextState = S_FINISH;
                        finishErr = 1'b1;
                    end else begin
                        nextState = S_SUBLOAD;
                    end
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                nextState = S_IDLE;
            end
            default: nextState = S_IDLE;
        endcase
    end

    // Operand capture on accept; A is consumed two bits per iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            aReg <= '0;
            bReg <= '0;
            mReg <= '0;
        end else if (state == S_IDLE && start) begin
            aReg <= in_a;
            bReg <= in_b;
            mReg <= in_m;
        end else if (state == S_ITER) begin
            aReg <= {2'b00, aReg[511:2]};
        end
    end

    // Iteration, phase and subtraction-round counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            iterCnt  <= '0;
            phaseCnt <= '0;
            roundCnt <= '0;
        end else begin
            if (state == S_CLEAR)     iterCnt <= '0;
            else if (state == S_ITER) iterCnt <= iterCnt + 1'b1;
            if (state == S_CLEAR)        roundCnt <= '0;
            else if (state == S_SUBLOAD) roundCnt <= roundCnt + 1'b1;
            unique case (state)
                S_RESOLVE, S_SUBRND:
                    phaseCnt <= (phaseCnt == PH_LAST) ? 3'd0 : phaseCnt + 1'b1;
                S_SUBLOAD: phaseCnt <= 3'd1;
                default:   phaseCnt <= 3'd0;
            endcase
        end
    end

    // Error flag for the pending done and the held result word.
    always_ff @(posedge clk) begin
        if (reset) begin
            errFlag <= 1'b0;
            result  <= '0;
        end else begin
            if (state == S_CLEAR) errFlag <= 1'b0;
            else if (state == S_SUBRND && nextState == S_FINISH) errFlag <= finishErr;
            if (state == S_FINISH) result <= add_result[511:0];
        end
    end

endmodule
